// File: rtl/fir_input_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fir_input_sequencer                                            |
// | Brief   : Turns bus events into FIR controller lc/dr handshakes, with a  |
// |           2-entry sample queue. Optional macro: FIR_SEQ_TIMEOUT_EN.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fir_input_sequencer #(
  parameter int SAMPLE_W       = 16,
  parameter int NUM_COEFF      = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_coeff_set,
  input  logic                         sample_valid,
  input  logic [SAMPLE_W-1:0]          sample_in,
  input  logic                         modwait,
  output logic                         sample_ready,
  output logic                         lc,
  output logic [$clog2(NUM_COEFF)-1:0] coeff_sel,
  output logic                         dr,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         coeff_done,
  output logic                         busy,
  output logic                         err_timeout
);

  localparam int c_sel_w = $clog2(NUM_COEFF);
  localparam logic [c_sel_w-1:0] c_last_sel = c_sel_w'(NUM_COEFF - 1);

  typedef enum logic [2:0] {
    IDLE, C_LOAD, C_WAIT_HI, C_WAIT_LO, C_DONE, S_PRESENT, S_WAIT_HI, S_WAIT_LO
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_sel_w-1:0]  r_coeff_sel;
  logic [SAMPLE_W-1:0] r_mem [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                w_push;
  logic                w_pop;
  logic                w_timeout;
  logic                w_in_coeff;

  assign w_in_coeff = (r_state == C_LOAD) || (r_state == C_WAIT_HI) ||
                      (r_state == C_WAIT_LO) || (r_state == C_DONE);

  assign sample_ready = !rst && (r_count != 2'd2) && !w_in_coeff;
  assign w_push       = sample_valid && sample_ready;

  assign lc         = (r_state == C_LOAD);
  assign coeff_done = (r_state == C_DONE);
  assign dr         = (r_state == S_PRESENT) || (r_state == S_WAIT_HI) ||
                      (r_state == S_WAIT_LO);
  assign busy       = !((r_state == IDLE) && (r_count == 2'd0));
  assign coeff_sel  = r_coeff_sel;
  assign sample_out = r_mem[r_rd_ptr];

  // Wait for modwait to rise. The timeout path is constant-0 unless enabled.
`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_err;
  logic              w_wait_hi;

  assign w_wait_hi   = (r_state == C_WAIT_HI) || (r_state == S_WAIT_HI);
  assign w_timeout   = w_wait_hi && !modwait && (r_to_cnt == c_to_last);
  assign err_timeout = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_wait_hi && !modwait && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
      else                                     r_to_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (new_coeff_set)        w_state_nxt = C_LOAD;
        else if (r_count != 2'd0) w_state_nxt = S_PRESENT;
      end
      C_LOAD:    w_state_nxt = C_WAIT_HI;
      C_WAIT_HI: begin
        if (modwait)        w_state_nxt = C_WAIT_LO;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      C_WAIT_LO: begin
        if (!modwait) w_state_nxt = (r_coeff_sel == c_last_sel) ? C_DONE : C_LOAD;
      end
      C_DONE:    w_state_nxt = IDLE;
      S_PRESENT: w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: begin
        if (modwait) begin
          w_state_nxt = S_WAIT_LO;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_pop       = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!modwait) begin
          w_state_nxt = IDLE;
          w_pop       = 1'b1;
        end
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_coeff_sel <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == C_WAIT_LO) && !modwait && (r_coeff_sel != c_last_sel))
        r_coeff_sel <= r_coeff_sel + 1'b1;
      else if ((r_state == C_DONE) || ((r_state == C_WAIT_HI) && w_timeout) ||
               ((r_state == IDLE) && new_coeff_set))
        r_coeff_sel <= '0;
    end
  end

  // Two-entry circular queue; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= sample_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_input_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fir_input_sequencer                                         |
// | Brief   : Directed self-checking bench with a reactive modwait model.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fir_input_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_coeff_set;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        modwait = 1'b0;
  logic        sample_ready;
  logic        lc;
  logic [1:0]  coeff_sel;
  logic        dr;
  logic [15:0] sample_out;
  logic        coeff_done;
  logic        busy;
  logic        err_timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_input_sequencer #(
    .SAMPLE_W(16), .NUM_COEFF(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .new_coeff_set(new_coeff_set),
    .sample_valid(sample_valid), .sample_in(sample_in), .modwait(modwait),
    .sample_ready(sample_ready), .lc(lc), .coeff_sel(coeff_sel), .dr(dr),
    .sample_out(sample_out), .coeff_done(coeff_done), .busy(busy),
    .err_timeout(err_timeout)
  );

  // Controller model: modwait high for mw_len cycles after lc or a dr rise
  int   mw_len = 2;
  bit   mw_en  = 1'b1;
  int   mw_cnt = 0;
  logic dr_q   = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mw_cnt = 0;
      dr_q   = 1'b0;
      modwait <= 1'b0;
    end else begin
      if (mw_cnt > 0) begin
        mw_cnt--;
        if (mw_cnt == 0) modwait <= 1'b0;
      end
      if (mw_en && (lc || (dr && !dr_q))) begin
        mw_cnt = mw_len;
        modwait <= 1'b1;
      end
      dr_q = dr;
    end
  end

  // Handshake monitor
  int          cyc = 0;
  int          lc_sels[$];
  int          lc_long = 0;
  int          done_cnt = 0;
  logic [15:0] dr_outs[$];
  int          dr_lens[$];
  int          dr_run = 0;
  int          drop_err = 0;
  int          unstable = 0;
  int          last_lc_cyc = -1;
  int          first_dr_cyc = -1;
  logic        lc_p = 1'b0;
  logic        dr_p = 1'b0;
  logic [15:0] so_p = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (lc) begin
        lc_sels.push_back(int'(coeff_sel));
        last_lc_cyc = cyc;
        if (lc_p) lc_long++;
      end
      if (coeff_done) done_cnt++;
      if (dr && !dr_p) begin
        dr_outs.push_back(sample_out);
        if (first_dr_cyc < 0) first_dr_cyc = cyc;
        dr_run = 0;
      end
      if (dr) begin
        dr_run++;
        if (dr_p && (sample_out !== so_p)) unstable++;
      end
      if (!dr && dr_p) begin
        dr_lens.push_back(dr_run);
        if (modwait) drop_err++;
      end
    end
    lc_p = rst ? 1'b0 : lc;
    dr_p = rst ? 1'b0 : dr;
    so_p = sample_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return lc;
      1:       return coeff_done;
      2:       return dr;
      3:       return sample_ready;
      4:       return busy;
      default: return 1'bx;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input logic lvl, input int budget);
    int k = 0;
    while ((sig(w) !== lvl) && (k < budget)) begin
      step(1);
      k++;
    end
    chk(tag, {31'd0, sig(w)}, {31'd0, lvl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; new_coeff_set = 1'b0; sample_valid = 1'b0; sample_in = '0;
    step(2);
    chk("rst_lc", lc, 0);
    chk("rst_dr", dr, 0);
    chk("rst_sel", coeff_sel, 0);
    chk("rst_done", coeff_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ready", sample_ready, 0);
    chk("rst_sout", sample_out, 0);
    rst = 1'b0;
    step(1);
    chk("rel_ready", sample_ready, 1);
    chk("rel_busy", busy, 0);

    // 1: reset while waiting for modwait to fall on coefficient 1
    mw_len = 6;
    new_coeff_set = 1'b1;
    step(1);
    chk("t1_lc_lat", lc, 1);
    chk("t1_sel0", coeff_sel, 0);
    step(1);
    wait_for("t1_lc2", 0, 1'b1, 20);
    chk("t1_sel1", coeff_sel, 1);
    step(3);
    chk("t1_busy", busy, 1);
    chk("t1_lc_lo", lc, 0);
    rst = 1'b1; new_coeff_set = 1'b0;
    step(1);
    chk("t1_r_sel", coeff_sel, 0);
    chk("t1_r_busy", busy, 0);
    chk("t1_r_lc", lc, 0);
    chk("t1_r_ready", sample_ready, 0);
    rst = 1'b0;
    step(1);
    chk("t1_p_ready", sample_ready, 1);
    chk("t1_p_busy", busy, 0);
    chk("t1_p_lc", lc, 0);

    // 2: full reload
    lc_sels.delete(); done_cnt = 0; mw_len = 2;
    new_coeff_set = 1'b1;
    step(1);
    chk("t2_lc_lat", lc, 1);
    wait_for("t2_done", 1, 1'b1, 60);
    new_coeff_set = 1'b0;
    step(3);
    chk("t2_nlc", lc_sels.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_sel%0d", i), (i < lc_sels.size()) ? lc_sels[i] : 99, i);
    chk("t2_ndone", done_cnt, 1);
    chk("t2_busy", busy, 0);
    chk("t2_sel_end", coeff_sel, 0);

    // 3: back-to-back samples, third stalls on a full queue
    dr_outs.delete(); dr_lens.delete(); mw_len = 12;
    sample_in = 16'h1234; sample_valid = 1'b1;
    chk("t3_rdy0", sample_ready, 1);
    step(1);
    sample_in = 16'h8001;
    chk("t3_dr_j1", dr, 0);
    chk("t3_rdy1", sample_ready, 1);
    step(1);
    sample_in = 16'h5A5A;
    chk("t3_dr_lat", dr, 1);
    chk("t3_sout0", sample_out, 16'h1234);
    chk("t3_full", sample_ready, 0);
    step(5);
    chk("t3_full_hold", sample_ready, 0);
    chk("t3_dr_hold", dr, 1);
    chk("t3_sout_hold", sample_out, 16'h1234);
    wait_for("t3_rdy_back", 3, 1'b1, 20);
    chk("t3_dr_gap", dr, 0);
    step(1);
    sample_valid = 1'b0;
    chk("t3_dr2", dr, 1);
    chk("t3_sout1", sample_out, 16'h8001);
    wait_for("t3_idle", 4, 1'b0, 120);
    chk("t3_nout", dr_outs.size(), 3);
    chk("t3_out0", (dr_outs.size() > 0) ? dr_outs[0] : 16'hDEAD, 16'h1234);
    chk("t3_out1", (dr_outs.size() > 1) ? dr_outs[1] : 16'hDEAD, 16'h8001);
    chk("t3_out2", (dr_outs.size() > 2) ? dr_outs[2] : 16'hDEAD, 16'h5A5A);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3_len%0d", i), (i < dr_lens.size()) ? dr_lens[i] : 0, 13);

    // 4: coefficient reload and sample arrive together
    lc_sels.delete(); done_cnt = 0; dr_outs.delete(); first_dr_cyc = -1;
    mw_len = 2;
    new_coeff_set = 1'b1; sample_valid = 1'b1; sample_in = 16'hBEEF;
    chk("t4_rdy", sample_ready, 1);
    step(1);
    sample_valid = 1'b0;
    chk("t4_lc", lc, 1);
    chk("t4_dr", dr, 0);
    chk("t4_busy", busy, 1);
    wait_for("t4_done", 1, 1'b1, 60);
    new_coeff_set = 1'b0;
    wait_for("t4_dr_up", 2, 1'b1, 10);
    chk("t4_sout", sample_out, 16'hBEEF);
    chk("t4_nlc", lc_sels.size(), 4);
    chk("t4_order", (last_lc_cyc < first_dr_cyc), 1);
    chk("t4_ndone", done_cnt, 1);
    wait_for("t4_idle", 4, 1'b0, 40);

    // 5: reload request arriving mid-sample is deferred
    dr_lens.delete(); lc_sels.delete(); mw_len = 6;
    sample_in = 16'h0F0F; sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    step(1);
    chk("t5_dr", dr, 1);
    step(3);
    new_coeff_set = 1'b1;
    chk("t5_dr_held", dr, 1);
    chk("t5_no_lc", lc, 0);
    step(1);
    chk("t5_dr_held2", dr, 1);
    chk("t5_no_lc2", lc, 0);
    wait_for("t5_dr_lo", 2, 1'b0, 10);
    chk("t5_lc_idle", lc, 0);
    step(1);
    chk("t5_lc", lc, 1);
    wait_for("t5_done", 1, 1'b1, 60);
    new_coeff_set = 1'b0;
    wait_for("t5_idle", 4, 1'b0, 20);
    chk("t5_len", (dr_lens.size() > 0) ? dr_lens[0] : 0, 7);
    chk("t5_nlc", lc_sels.size(), 4);

    chk("g_drop", drop_err, 0);
    chk("g_unstable", unstable, 0);
    chk("g_lc_long", lc_long, 0);
    chk("g_err", err_timeout, 0);

`ifdef FIR_SEQ_TIMEOUT_EN
    // 6: modwait never rises after lc
    mw_en = 1'b0;
    new_coeff_set = 1'b1;
    step(1);
    chk("t6_lc", lc, 1);
    step(7);
    chk("t6_err_7", err_timeout, 0);
    chk("t6_busy", busy, 1);
    step(1);
    chk("t6_err_8", err_timeout, 0);
    step(1);
    chk("t6_err_set", err_timeout, 1);
    chk("t6_lc_lo", lc, 0);
    chk("t6_sel", coeff_sel, 0);
    chk("t6_idle", busy, 0);
    new_coeff_set = 1'b0;
    step(3);
    chk("t6_sticky", err_timeout, 1);
    chk("t6_lc_off", lc, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
